// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/word requests into accesses on a simple byte-addressed memory port.
// Optional macro LSU_MISALIGNED_SPLIT_EN splits misaligned word accesses into four byte accesses.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic                     req_byte,
    input  logic                     req_sign,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     WE,
    output logic                     addr_mode,
    output logic [ADDRESS_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0]    WD,
    input  logic [DATA_WIDTH-1:0]    RD
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                   state;
    logic                     lat_we;
    logic                     lat_byte;
    logic                     lat_sign;
    logic                     lat_split;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic [DATA_WIDTH-1:0]    rdata_acc;
    logic [DATA_WIDTH-1:0]    acc_next;
    logic [DATA_WIDTH-1:0]    single_result;
    logic [1:0]               byte_cnt;
    logic [1:0]               next_cnt;
    logic                     req_split;
    logic                     last_access;

    assign req_split   = !req_byte && (req_addr[1:0] != 2'b00);
    assign next_cnt    = byte_cnt + 2'd1;
    assign last_access = !lat_split || (byte_cnt == 2'd3);

    // Split loads assemble the word one byte lane at a time, little-endian.
    always_comb begin
        acc_next = rdata_acc;
        acc_next[8*byte_cnt +: 8] = RD[7:0];
    end

    always_comb begin
        if (!lat_byte) begin
            single_result = RD;
        end else if (lat_sign) begin
            single_result = {{(DATA_WIDTH-8){RD[7]}}, RD[7:0]};
        end else begin
            single_result = {{(DATA_WIDTH-8){1'b0}}, RD[7:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            WE         <= 1'b0;
            addr_mode  <= 1'b0;
            A          <= '0;
            WD         <= '0;
            byte_cnt   <= '0;
            rdata_acc  <= '0;
            lat_we     <= 1'b0;
            lat_byte   <= 1'b0;
            lat_sign   <= 1'b0;
            lat_split  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_byte  <= req_byte;
                        lat_sign  <= req_sign;
                        lat_split <= req_split;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        byte_cnt  <= '0;
                        rdata_acc <= '0;
                        req_ready <= 1'b0;
                        // Without split support a misaligned word is rejected without touching memory.
                        if (req_split && !SPLIT_EN) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ACCESS;
                            WE        <= req_we;
                            addr_mode <= req_byte || req_split;
                            A         <= req_addr;
                            WD        <= req_split ? {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]}
                                                   : req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (last_access) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        if (lat_we) begin
                            resp_rdata <= '0;
                        end else if (lat_split) begin
                            resp_rdata <= acc_next;
                        end else begin
                            resp_rdata <= single_result;
                        end
                        WE        <= 1'b0;
                        addr_mode <= 1'b0;
                        A         <= '0;
                        WD        <= '0;
                        byte_cnt  <= '0;
                    end else begin
                        byte_cnt  <= next_cnt;
                        rdata_acc <= acc_next;
                        A         <= lat_addr + ADDRESS_WIDTH'(next_cnt);
                        WD        <= {{(DATA_WIDTH-8){1'b0}}, lat_wdata[8*next_cnt +: 8]};
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    WE         <= 1'b0;
                end
            endcase
        end
    end

endmodule
